// File: rtl/tds_chk_pkg.sv
// Shared definitions for the TDS link checker.
// Provides the per-lane state encoding, the default sync pattern and default widths.
package tds_chk_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLinked = 2'd2
  } lane_state_e;

  localparam logic [19:0] SyncWordDefault = 20'h5A3C5;
  localparam int unsigned DataWDefault    = 20;
  localparam int unsigned CntWDefault     = 16;
  localparam int unsigned ErrWDefault     = 16;

endpackage

// File: rtl/tds_chk_lane.sv
// One lane of the TDS link checker: word lock on a sync pattern, then test-counter checking.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   word_i         lane word from the GTP
//   valid_i        word strobe; the lane only advances on valid words
//   enable_i       lane enable; low forces HUNT without flagging a lock loss
//   clear_i        synchronous clear of err_cnt_o and lock_lost_o (wins over updates)
//   linked_o       lane is in LINKED
//   err_cnt_o      saturating payload-error count
//   lock_lost_o    sticky: lane left LINKED because of errors or timeout
//
// Optional: define TDS_CHK_WATCHDOG_EN to drop lock after TIMEOUT idle cycles in LINKED.
module tds_chk_lane
  import tds_chk_pkg::*;
#(
  parameter int unsigned       DATA_W     = DataWDefault,
  parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(SyncWordDefault),
  parameter int unsigned       CNT_W      = CntWDefault,
  parameter int unsigned       LOCK_CNT   = 8,
  parameter int unsigned       UNLOCK_ERR = 4,
  parameter int unsigned       ERR_W      = ErrWDefault,
  parameter int unsigned       TIMEOUT    = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] word_i,
  input  logic              valid_i,
  input  logic              enable_i,
  input  logic              clear_i,
  output logic              linked_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              lock_lost_o
);

  localparam int unsigned SyncW   = $clog2(LOCK_CNT + 1);
  localparam int unsigned ConsecW = $clog2(UNLOCK_ERR + 1);

  lane_state_e        state_q, state_d;
  logic [SyncW-1:0]   sync_q, sync_d;
  logic [CNT_W-1:0]   exp_q, exp_d;
  logic               seeded_q, seeded_d;
  logic [ConsecW-1:0] consec_q, consec_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               lost_q, lost_d;

`ifdef TDS_CHK_WATCHDOG_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  logic [IdleW-1:0] idle_q, idle_d;
`endif

  logic             is_sync;
  logic [CNT_W-1:0] payload;
  logic [CNT_W-1:0] payload_inc;

  assign is_sync     = (word_i == SYNC_WORD);
  assign payload     = word_i[CNT_W-1:0];
  assign payload_inc = payload + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    exp_d    = exp_q;
    seeded_d = seeded_q;
    consec_d = consec_q;
    err_d    = err_q;
    lost_d   = lost_q;
`ifdef TDS_CHK_WATCHDOG_EN
    idle_d   = idle_q;
`endif

    if (!enable_i) begin
      state_d  = StHunt;
      sync_d   = '0;
      seeded_d = 1'b0;
      consec_d = '0;
`ifdef TDS_CHK_WATCHDOG_EN
      idle_d   = '0;
`endif
    end else if (valid_i) begin
`ifdef TDS_CHK_WATCHDOG_EN
      idle_d = '0;
`endif
      case (state_q)
        StHunt: begin
          if (is_sync) begin
            if (LOCK_CNT <= 1) begin
              state_d = StLinked;
              sync_d  = '0;
            end else begin
              state_d = StVerify;
              sync_d  = SyncW'(1);
            end
          end
        end
        StVerify: begin
          if (is_sync) begin
            if (sync_q + SyncW'(1) == SyncW'(LOCK_CNT)) begin
              state_d = StLinked;
              sync_d  = '0;
            end else begin
              sync_d = sync_q + SyncW'(1);
            end
          end else begin
            state_d = StHunt;
            sync_d  = '0;
          end
        end
        StLinked: begin
          // Sync words in LINKED are idle fill and leave the expected value alone.
          if (!is_sync) begin
            exp_d = payload_inc;
            if (!seeded_q) begin
              seeded_d = 1'b1;
            end else if (payload != exp_q) begin
              if (err_q != '1) err_d = err_q + ERR_W'(1);
              if (consec_q + ConsecW'(1) == ConsecW'(UNLOCK_ERR)) begin
                state_d  = StHunt;
                lost_d   = 1'b1;
                seeded_d = 1'b0;
                consec_d = '0;
              end else begin
                consec_d = consec_q + ConsecW'(1);
              end
            end else begin
              consec_d = '0;
            end
          end
        end
        default: begin
          state_d = StHunt;
          sync_d  = '0;
        end
      endcase
    end
`ifdef TDS_CHK_WATCHDOG_EN
    else if (state_q == StLinked) begin
      if (idle_q == IdleW'(TIMEOUT - 1)) begin
        state_d  = StHunt;
        lost_d   = 1'b1;
        seeded_d = 1'b0;
        consec_d = '0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
`endif

    if (clear_i) begin
      err_d  = '0;
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StHunt;
      sync_q   <= '0;
      exp_q    <= '0;
      seeded_q <= 1'b0;
      consec_q <= '0;
      err_q    <= '0;
      lost_q   <= 1'b0;
`ifdef TDS_CHK_WATCHDOG_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      exp_q    <= exp_d;
      seeded_q <= seeded_d;
      consec_q <= consec_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
`ifdef TDS_CHK_WATCHDOG_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign linked_o    = (state_q == StLinked);
  assign err_cnt_o   = err_q;
  assign lock_lost_o = lost_q;

endmodule

// File: rtl/tds_link_checker.sv
// Parametrised N-lane TDS link checker (readout clock domain, after GTP wrapper and lane CDC).
//
// Ports:
//   clk_readout  readout clock
//   reset_n      asynchronous active-low reset
//   rx_data      lane words, lane k in bits [k*DATA_W +: DATA_W]
//   rx_valid     per-lane word strobe
//   ch_enable    per-lane enable mask
//   clear_cnt    synchronous clear of err_cnt and lock_lost
//   linked       per-lane LINKED status
//   err_cnt      per-lane saturating error counts, lane k in bits [k*ERR_W +: ERR_W]
//   lock_lost    per-lane sticky lock-loss flags
//   all_linked   registered AND of linked over enabled lanes; 0 if none enabled
//
// Optional: define TDS_CHK_WATCHDOG_EN to enable the per-lane idle watchdog (TIMEOUT cycles).
module tds_link_checker
  import tds_chk_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       DATA_W     = DataWDefault,
  parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(SyncWordDefault),
  parameter int unsigned       CNT_W      = CntWDefault,
  parameter int unsigned       LOCK_CNT   = 8,
  parameter int unsigned       UNLOCK_ERR = 4,
  parameter int unsigned       ERR_W      = ErrWDefault,
  parameter int unsigned       TIMEOUT    = 1024
) (
  input  logic                     clk_readout,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     clear_cnt,
  output logic [NUM_CH-1:0]        linked,
  output logic [NUM_CH*ERR_W-1:0]  err_cnt,
  output logic [NUM_CH-1:0]        lock_lost,
  output logic                     all_linked
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tds_chk_lane #(
      .DATA_W    (DATA_W),
      .SYNC_WORD (SYNC_WORD),
      .CNT_W     (CNT_W),
      .LOCK_CNT  (LOCK_CNT),
      .UNLOCK_ERR(UNLOCK_ERR),
      .ERR_W     (ERR_W),
      .TIMEOUT   (TIMEOUT)
    ) u_lane (
      .clk_i      (clk_readout),
      .rst_ni     (reset_n),
      .word_i     (rx_data[k*DATA_W +: DATA_W]),
      .valid_i    (rx_valid[k]),
      .enable_i   (ch_enable[k]),
      .clear_i    (clear_cnt),
      .linked_o   (linked[k]),
      .err_cnt_o  (err_cnt[k*ERR_W +: ERR_W]),
      .lock_lost_o(lock_lost[k])
    );
  end

  logic all_linked_q, all_linked_d;

  // Disabled lanes are masked to 1 so they do not block the reduction.
  assign all_linked_d = (|ch_enable) && (&(linked | ~ch_enable));

  always_ff @(posedge clk_readout or negedge reset_n) begin
    if (!reset_n) begin
      all_linked_q <= 1'b0;
    end else begin
      all_linked_q <= all_linked_d;
    end
  end

  assign all_linked = all_linked_q;

endmodule

// File: tb/tb_tds_link_checker.sv
module tb_tds_link_checker;

  localparam int unsigned NumCh  = 4;
  localparam int unsigned DataW  = 20;
  localparam int unsigned ErrW   = 8;
  localparam logic [19:0] Sync   = 20'h5A3C5;

  logic                   clk_readout;
  logic                   reset_n;
  logic [NumCh*DataW-1:0] rx_data;
  logic [NumCh-1:0]       rx_valid;
  logic [NumCh-1:0]       ch_enable;
  logic                   clear_cnt;
  logic [NumCh-1:0]       linked;
  logic [NumCh*ErrW-1:0]  err_cnt;
  logic [NumCh-1:0]       lock_lost;
  logic                   all_linked;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] prev;

  tds_link_checker #(
    .NUM_CH    (NumCh),
    .DATA_W    (DataW),
    .SYNC_WORD (Sync),
    .CNT_W     (16),
    .LOCK_CNT  (8),
    .UNLOCK_ERR(4),
    .ERR_W     (ErrW),
    .TIMEOUT   (16)
  ) dut (
    .clk_readout(clk_readout),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ch_enable  (ch_enable),
    .clear_cnt  (clear_cnt),
    .linked     (linked),
    .err_cnt    (err_cnt),
    .lock_lost  (lock_lost),
    .all_linked (all_linked)
  );

  initial clk_readout = 1'b0;
  always #5 clk_readout = ~clk_readout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One valid word on lane 0, sampled 1 time unit after the accepting edge.
  task automatic send(input logic [19:0] w);
    rx_data[19:0] = w;
    rx_valid      = 4'b0001;
    @(posedge clk_readout);
    #1;
    rx_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_readout);
      #1;
    end
  endtask

  task automatic lock0();
    repeat (8) send(Sync);
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_data   = '0;
    rx_valid  = '0;
    ch_enable = 4'b0001;
    clear_cnt = 1'b0;
    idle(2);
    check("reset_linked", 32'(linked), 32'h0);
    check("reset_err", err_cnt, 32'h0);
    check("reset_lost", 32'(lock_lost), 32'h0);
    check("reset_all", 32'(all_linked), 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Lock acquisition
    repeat (7) send(Sync);
    check("lock_7th", 32'(linked), 32'h0);
    send(Sync);
    check("lock_8th", 32'(linked), 32'h1);
    check("all_lag", 32'(all_linked), 32'h0);
    idle(1);
    check("all_one", 32'(all_linked), 32'h1);
    ch_enable = 4'b0011;
    idle(1);
    check("all_two_en", 32'(all_linked), 32'h0);
    ch_enable = 4'b0000;
    idle(1);
    check("all_none_en", 32'(all_linked), 32'h0);
    check("dis_unlock", 32'(linked), 32'h0);
    check("dis_no_lost", 32'(lock_lost), 32'h0);
    ch_enable = 4'b0001;
    lock0();
    check("relock", 32'(linked), 32'h1);

    // Counter wrap with interleaved syncs
    send(20'h0FFFE);
    send(Sync);
    send(20'h0FFFF);
    send(Sync);
    send(20'h00000);
    send(20'h00001);
    check("wrap_err", err_cnt, 32'h0);
    check("wrap_linked", 32'(linked), 32'h1);

    // Errors and unlock (drop enable to clear the seed first)
    ch_enable = 4'b0000;
    idle(1);
    ch_enable = 4'b0001;
    lock0();
    send(20'h00010);
    send(20'h00012);
    check("err_one", err_cnt, 32'h1);
    send(20'h00013);
    send(20'h00020);
    send(20'h00030);
    send(20'h00040);
    check("err_four", err_cnt, 32'h4);
    check("still_linked", 32'(linked), 32'h1);
    send(20'h00050);
    check("err_five", err_cnt, 32'h5);
    check("unlock", 32'(linked), 32'h0);
    check("lost_set", 32'(lock_lost), 32'h1);

    // Broken sync
    repeat (4) send(Sync);
    send(20'h00001);
    check("broken", 32'(linked), 32'h0);
    repeat (7) send(Sync);
    check("broken_7", 32'(linked), 32'h0);
    send(Sync);
    check("broken_8", 32'(linked), 32'h1);
    check("lost_sticky", 32'(lock_lost), 32'h1);

    // Clear alone
    clear_cnt = 1'b1;
    idle(1);
    clear_cnt = 1'b0;
    check("clr_err", err_cnt, 32'h0);
    check("clr_lost", 32'(lock_lost), 32'h0);
    check("clr_state", 32'(linked), 32'h1);

    // Saturation: groups of three mismatches and one match keep the lane linked
    prev = 16'h0100;
    send({4'h0, prev});
    for (int g = 0; g < 90; g++) begin
      for (int m = 0; m < 3; m++) begin
        prev = prev + 16'd2;
        send({4'h0, prev});
      end
      prev = prev + 16'd1;
      send({4'h0, prev});
    end
    check("sat_err", err_cnt, 32'hFF);
    check("sat_linked", 32'(linked), 32'h1);
    prev = prev + 16'd2;
    send({4'h0, prev});
    check("sat_hold", err_cnt, 32'hFF);
    clear_cnt = 1'b1;
    prev = prev + 16'd2;
    send({4'h0, prev});
    clear_cnt = 1'b0;
    check("clr_vs_inc", err_cnt, 32'h0);
    prev = prev + 16'd2;
    send({4'h0, prev});
    check("post_clr_inc", err_cnt, 32'h1);
    clear_cnt = 1'b1;
    prev = prev + 16'd2;
    send({4'h0, prev});
    clear_cnt = 1'b0;
    check("clr_vs_loss_err", err_cnt, 32'h0);
    check("clr_vs_loss_lost", 32'(lock_lost), 32'h0);
    check("clr_vs_loss_unlk", 32'(linked), 32'h0);

    // Watchdog
    lock0();
    idle(15);
    check("wd_15", 32'(linked), 32'h1);
    idle(1);
`ifdef TDS_CHK_WATCHDOG_EN
    check("wd_linked", 32'(linked), 32'h0);
    check("wd_lost", 32'(lock_lost), 32'h1);
`else
    check("wd_linked", 32'(linked), 32'h1);
    check("wd_lost", 32'(lock_lost), 32'h0);
`endif

    // Mid-frame asynchronous reset
    lock0();
    clear_cnt = 1'b1;
    idle(1);
    clear_cnt = 1'b0;
    send(20'h00100);
    send(20'h00200);
    check("pre_rst_err", err_cnt, 32'h1);
    check("pre_rst_linked", 32'(linked), 32'h1);
    check("other_lanes", err_cnt[31:8], 32'h0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_linked", 32'(linked), 32'h0);
    check("arst_err", err_cnt, 32'h0);
    check("arst_all", 32'(all_linked), 32'h0);
    idle(1);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
